// File: rtl/aes_pipe_pkg.sv
// Shared AES pipeline definitions: block width, encryptor latency
// and the ciphertext block type.
package aes_pipe_pkg;
   localparam int AES_BLOCK_W        = 128;
   localparam int AES128_ENC_LATENCY = 11;
   typedef logic [AES_BLOCK_W-1:0] blk_t;
endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO only lands when a pop frees the slot.
module aes_blk_fifo
   import aes_pipe_pkg::*;
#(
   parameter int W     = AES_BLOCK_W,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_cnt;
   logic [AW:0]  rd_cnt;
   logic         do_pop;
   logic         do_push;

   assign level   = wr_cnt - rd_cnt;
   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (do_push)
            wr_cnt <= wr_cnt + (AW+1)'(1);
         if (do_pop)
            rd_cnt <= rd_cnt + (AW+1)'(1);
      end
   end

   // storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_cnt[AW-1:0]] <= din;
   end

   assign dout = empty ? '0 : mem[rd_cnt[AW-1:0]];
endmodule

// File: rtl/aes_enc_collector.sv
// Collects ciphertext from the fixed-latency AES encryptor into a FIFO.
// Optional delivered-block counter: define AES_COLLECT_CNT_EN.
module aes_enc_collector
   import aes_pipe_pkg::*;
#(
   parameter int BLOCK_LENGTH = AES_BLOCK_W,
   parameter int LATENCY      = AES128_ENC_LATENCY,
   parameter int DEPTH        = 16,
   localparam int AW          = $clog2(DEPTH),
   localparam int IW          = $clog2(LATENCY+1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enc_enable,
   input  logic [BLOCK_LENGTH-1:0] enc_out,
   output logic                    accept,
   output logic [BLOCK_LENGTH-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [AW:0]             level,
   output logic                    overflow,
   output logic [31:0]             blk_count
);
   logic [LATENCY-1:0] dl;
   logic [IW-1:0]      inflight;
   logic               cap;
   logic               pop;
   logic               full;
   logic               empty;
   logic [AW:0]        lvl;

   assign cap       = dl[LATENCY-1];
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign level     = lvl;

   // same-cycle pops are not credited, so the issuer is held back early
   assign accept = (32'(lvl) + 32'(inflight)) < 32'(DEPTH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         dl       <= '0;
         inflight <= '0;
         overflow <= 1'b0;
      end else begin
         dl[0] <= enc_enable;
         for (int k = 1; k < LATENCY; k++)
            dl[k] <= dl[k-1];
         unique case ({enc_enable, cap})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: inflight <= inflight;
         endcase
         if (cap && full && !pop)
            overflow <= 1'b1;
      end
   end

   aes_blk_fifo #(
      .W     (BLOCK_LENGTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap),
      .din   (enc_out),
      .pop   (pop),
      .dout  (out_data),
      .full  (full),
      .empty (empty),
      .level (lvl)
   );

`ifdef AES_COLLECT_CNT_EN
   logic [31:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst)
         cnt <= '0;
      else if (pop)
         cnt <= cnt + 32'd1;
   end

   assign blk_count = cnt;
`else
   assign blk_count = '0;
`endif
endmodule

// File: tb/tb_aes_enc_collector.sv
// Self-checking bench for aes_enc_collector with a behavioural
// fixed-latency encryptor model and an output scoreboard.
`timescale 1ns/1ps
module tb_aes_enc_collector;
   import aes_pipe_pkg::*;

   localparam int L     = AES128_ENC_LATENCY;
   localparam int DEPTH = 16;
`ifdef AES_COLLECT_CNT_EN
   localparam int EXP_CNT = 20;
`else
   localparam int EXP_CNT = 0;
`endif

   typedef struct {
      int   n;
      logic rdy;
      int   lvl;
      logic acc;
      logic ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enc_enable = 1'b0;
   logic        out_ready = 1'b0;
   blk_t        enc_in = '0;
   blk_t        enc_out;
   blk_t        out_data;
   logic        accept;
   logic        out_valid;
   logic        overflow;
   logic [4:0]  level;
   logic [31:0] blk_count;

   int   n_checks = 0;
   int   n_fail = 0;
   blk_t exp_q[$];

   blk_t         pd [L];
   logic [L-1:0] pv;

   always #5 clk = ~clk;

   aes_enc_collector dut (
      .clk        (clk),
      .rst        (rst),
      .enc_enable (enc_enable),
      .enc_out    (enc_out),
      .accept     (accept),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .level      (level),
      .overflow   (overflow),
      .blk_count  (blk_count)
   );

   // encryptor model: value issued in cycle N appears in cycle N+L
   always @(posedge clk) begin
      if (!rst) begin
         pv <= '0;
      end else begin
         pv    <= {pv[L-2:0], enc_enable};
         pd[0] <= enc_in;
         for (int k = 1; k < L; k++)
            pd[k] <= pd[k-1];
      end
   end

   assign enc_out = pv[L-1] ? pd[L-1] : {4{32'hbadc0de5}};

   task automatic chk(input string name,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_unexpected: got %0h expected none",
                     out_data);
         end else begin
            chk("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   function automatic blk_t rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      enc_enable = 1'b0;
      tick();
      rst = 1'b1;
      exp_q.delete();
   endtask

   task automatic issue(input blk_t d, input bit force_it,
                        input bit keep);
      int w;
      w = 0;
      while (!force_it && !accept && w < 200) begin
         tick();
         w++;
      end
      if (w >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got 0 expected 1");
      end else begin
         enc_enable = 1'b1;
         enc_in = d;
         if (keep)
            exp_q.push_back(d);
         tick();
         enc_enable = 1'b0;
      end
   endtask

   initial begin
      vec_t tbl [4];
      int   first;
      int   nv;
      int   rises;
      int   drops;
      int   cnt;
      int   bad;
      logic prev;

      tbl[0] = '{3,  1'b0, 3,  1'b1, 1'b0};
      tbl[1] = '{13, 1'b0, 16, 1'b0, 1'b0};
      tbl[2] = '{0,  1'b1, 0,  1'b1, 1'b0};
      tbl[3] = '{5,  1'b1, 0,  1'b1, 1'b0};

      idle(2);
      reset_dut();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_accept", accept, 1);
      chk("rst_ovf", overflow, 0);
      chk("rst_cnt", blk_count, 0);

      // single block: exactly one valid cycle, L+1 after issue
      out_ready = 1'b1;
      enc_in = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      exp_q.push_back(enc_in);
      enc_enable = 1'b1;
      first = -1;
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            nv++;
            if (first < 0)
               first = i;
         end
         @(posedge clk);
         #1;
         enc_enable = 1'b0;
      end
      chk("single_latency", first, L + 1);
      chk("single_count", nv, 1);
      chk("single_level", level, 0);

      // streaming 20 back-to-back blocks
      reset_dut();
      out_ready = 1'b1;
      drops = 0;
      nv = 0;
      rises = 0;
      prev = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               if (!accept)
                  drops++;
               issue(rnd(), 1'b0, 1'b1);
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (out_valid) begin
                  nv++;
                  if (!prev)
                     rises++;
               end
               prev = out_valid;
            end
         end
      join
      chk("stream_drops", drops, 0);
      chk("stream_valid", nv, 20);
      chk("stream_bursts", rises, 1);
      chk("stream_ovf", overflow, 0);
      chk("stream_cnt", blk_count, EXP_CNT);

      // table-driven fill / drain phases
      reset_dut();
      for (int t = 0; t < 4; t++) begin
         out_ready = tbl[t].rdy;
         for (int j = 0; j < tbl[t].n; j++)
            issue(rnd(), 1'b0, 1'b1);
         idle(L + 20);
         chk($sformatf("tbl%0d_level", t), level, tbl[t].lvl);
         chk($sformatf("tbl%0d_accept", t), accept, tbl[t].acc);
         chk($sformatf("tbl%0d_ovf", t), overflow, tbl[t].ovf);
      end

      // credit limit, then forced overflow
      reset_dut();
      out_ready = 1'b0;
      cnt = 0;
      while (accept && cnt < 40) begin
         issue(rnd(), 1'b0, 1'b1);
         cnt++;
      end
      chk("credit_issues", cnt, DEPTH);
      idle(L + 3);
      chk("credit_level", level, DEPTH);
      chk("credit_ovf", overflow, 0);
      chk("credit_accept", accept, 0);
      issue(128'hdead_beef_dead_beef_dead_beef_dead_beef, 1'b1, 1'b0);
      idle(L + 2);
      chk("ovf_set", overflow, 1);
      chk("ovf_level", level, DEPTH);
      out_ready = 1'b1;
      idle(DEPTH + 4);
      chk("ovf_drain_level", level, 0);
      chk("ovf_sticky", overflow, 1);
      chk("ovf_leftover", exp_q.size(), 0);

      // full FIFO with capture and pop in the same cycle
      reset_dut();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         issue(rnd(), 1'b0, 1'b1);
      idle(L + 3);
      chk("fp_full", level, DEPTH);
      issue(rnd(), 1'b1, 1'b1);
      idle(L - 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("fp_level", level, DEPTH);
      chk("fp_ovf", overflow, 0);
      out_ready = 1'b1;
      idle(DEPTH + 4);
      chk("fp_leftover", exp_q.size(), 0);
      chk("fp_empty", level, 0);

      // reset with 3 stored and 5 in flight
      reset_dut();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         issue(rnd(), 1'b0, 1'b1);
      idle(L + 2);
      for (int i = 0; i < 5; i++)
         issue(rnd(), 1'b0, 1'b1);
      chk("mid_stored", level, 3);
      reset_dut();
      chk("mid_valid", out_valid, 0);
      chk("mid_level", level, 0);
      chk("mid_accept", accept, 1);
      bad = 0;
      for (int i = 0; i < L + 1; i++) begin
         tick();
         if (level != 0 || out_valid)
            bad++;
      end
      chk("mid_no_capture", bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
